fpu_issue_seq: RTL
==================

// Module: fpu_issue_seq
// PURPOSE
//  Issue/sequencing controller in front of the single-precision FPU (FPU_S).
//  Accepts one FP op at a time from decode via valid/ready and latches its operands, op and rounding mode.
//  Holds those values stable to the FPU, pulses start, and counts the per-op latency.
//  Captures result and fflags, then presents them to the FP register-file writeback port via valid/ready.
// PARAMETERS
//  LAT_ADDSUB   3  total cycles for FADD/FSUB (align + add/sub + round)
//  LAT_DEFAULT  1  total cycles for any other ALUop (FMUL/FDIV/special-case paths), must be >=1
//  CNT_W        4  latency counter width; LAT_* must be < 2**CNT_W
// PORTS
//  clk          in   1   clock
//  rst_n        in   1   reset, asynchronous, active-low
//  req_valid_i  in   1   decode has an FP op
//  req_ready_o  out  1   sequencer can accept (IDLE only)
//  req_op_i     in   6   ALUop (`ALU_OP_* encoding)
//  req_frm_i    in   3   resolved rounding mode
//  req_rs1_i    in   32  operand 1
//  req_rs2_i    in   32  operand 2
//  req_rs3_i    in   32  operand 3
//  req_rd_i     in   5   destination FP register
//  flush_i      in   1   pipeline flush: abort in-flight op
//  fpu_start_o  out  1   one-cycle start pulse to the FPU
//  fpu_op_o     out  6   latched ALUop
//  fpu_frm_o    out  3   latched rounding mode
//  fpu_rs1_o    out  32  latched operand 1
//  fpu_rs2_o    out  32  latched operand 2
//  fpu_rs3_o    out  32  latched operand 3
//  fpu_res_i    in   32  FPU result
//  fpu_fflags_i in   5   FPU flags {NV,DZ,OF,UF,NX}
//  wb_valid_o   out  1   result ready for writeback
//  wb_ready_i   in   1   writeback accepted
//  wb_rd_o      out  5   destination register
//  wb_data_o    out  32  result
//  wb_fflags_o  out  5   flags for this op
//  busy_o       out  1   state != IDLE (stalls FP decode)
// BEHAVIOUR
//  Reset: state=IDLE; counter=0; all latched/wb registers=0; req_ready_o=1; every other output=0.
//  States:
//   IDLE: req_ready_o=1. On req_valid_i&&!flush_i: latch op/frm/rs1-3/rd, load cnt=LAT(op)-1, go to EXEC.
//   EXEC: fpu_start_o=1 in the first EXEC cycle only. While cnt!=0, decrement.
//         When cnt==0, register fpu_res_i/fpu_fflags_i into wb_data/wb_fflags and go to DONE.
//   DONE: wb_valid_o=1, outputs held stable; on wb_ready_i go to IDLE. No accept in DONE (no bypass).
//  Latency: handshake in cycle T -> EXEC in T+1..T+LAT -> wb_valid_o from T+LAT+1.
//   FADD: T+4. LAT=1: T+2.
//  fpu_*_o stay stable from latch until the next accept; FPU inputs never change mid-op.
//  LAT(op): FADD/FSUB -> LAT_ADDSUB; all other encodings (incl. unknown) -> LAT_DEFAULT.
//  flush_i (any state): go to IDLE next cycle; cnt=0; wb_valid_o=0.
//   The aborted op never reaches writeback and does not update the accumulator.
//   flush_i beats a same-cycle request (request not accepted).
//  Flush in DONE with wb_ready_i high the same cycle: flush wins and the result is dropped.
//  Reset mid-op: immediate asynchronous return to IDLE; all registers cleared.
// CONFIGURATION
//  FPU_FFLAGS_ACCUM_EN defined:
//   adds ports fflags_acc_o out 5 (sticky fcsr.fflags) and fflags_clr_i in 1.
//   Each completed writeback (wb_valid_o&&wb_ready_i) ORs wb_fflags_o into fflags_acc_o.
//   fflags_clr_i clears it; if a writeback completes in the same cycle, the result is the new flags only.
//  FPU_FFLAGS_ACCUM_EN undefined: ports and register are absent; flags are visible only on wb_fflags_o.
// STRUCTURE
//  Shared header defines.vh: `ALU_OP_* codes, state encodings (IDLE/EXEC/DONE), fflags bit indices.
//  Sub-module fpu_lat_counter: load/decrement/zero-flag counter, CNT_W wide.
//  Op->latency decode and FSM stay in the top.
// TESTING
//  1. FADD 1.0+2.0 (3F800000+40000000), wb_ready_i=1 -> fpu_start_o at T+1 only; wb_valid at T+4;
//     data 40400000; fflags 0.
//  2. FMUL request, LAT_DEFAULT=1 -> wb_valid at T+2; req_ready_o low T+1..T+2.
//  3. FADD result with wb_ready_i low 5 cycles -> wb_valid/data held stable; back-to-back request
//     stalled until the wb handshake, then accepted the next IDLE cycle.
//  4. flush_i at T+2 of FADD -> IDLE at T+3; no wb_valid ever; next op accepted normally.
//  5. FADD inf+(-inf) (7F800000+FF800000) -> data 7FC00000, fflags 10000;
//     with FPU_FFLAGS_ACCUM_EN, fflags_acc_o=10000 until fflags_clr_i.
//  6. rst_n asserted during EXEC -> all outputs at reset values asynchronously; req_ready_o=1 after release.

Source files
------------

// File: rtl/fpu_issue_seq_pkg.sv
// Shared types and encodings for the FP issue sequencer: ALU op codes, FSM states,
// fflags bit positions and the request/writeback payload structs.
package fpu_issue_seq_pkg;

  localparam int unsigned OP_W     = 6;
  localparam int unsigned FRM_W    = 3;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned RD_W     = 5;
  localparam int unsigned FFLAGS_W = 5;

  localparam logic [OP_W-1:0] ALU_OP_FADD  = 6'h20;
  localparam logic [OP_W-1:0] ALU_OP_FSUB  = 6'h21;
  localparam logic [OP_W-1:0] ALU_OP_FMUL  = 6'h22;
  localparam logic [OP_W-1:0] ALU_OP_FDIV  = 6'h23;
  localparam logic [OP_W-1:0] ALU_OP_FSQRT = 6'h24;
  localparam logic [OP_W-1:0] ALU_OP_FMADD = 6'h25;

  localparam int unsigned FFLAG_NV = 4;
  localparam int unsigned FFLAG_DZ = 3;
  localparam int unsigned FFLAG_OF = 2;
  localparam int unsigned FFLAG_UF = 1;
  localparam int unsigned FFLAG_NX = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [FRM_W-1:0] frm;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
    logic [XLEN-1:0]  rs3;
    logic [RD_W-1:0]  rd;
  } fp_req_t;

  typedef struct packed {
    logic [RD_W-1:0]     rd;
    logic [XLEN-1:0]     data;
    logic [FFLAGS_W-1:0] fflags;
  } fp_wb_t;

endpackage

// File: rtl/fpu_issue_seq_lat.sv
// Load/decrement latency counter with a registered zero flag.
module fpu_lat_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zero_q;

  // clear beats load beats decrement; decrement saturates at zero
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= (cnt_d == '0);
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/fpu_issue_seq.sv
// Issue/sequencing controller in front of the single-precision FPU.
// Optional sticky fflags accumulator enabled by defining FPU_FFLAGS_ACCUM_EN.
module fpu_issue_seq
  import fpu_issue_seq_pkg::*;
#(
  parameter int unsigned LAT_ADDSUB  = 3,
  parameter int unsigned LAT_DEFAULT = 1,
  parameter int unsigned CNT_W       = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [OP_W-1:0]     req_op_i,
  input  logic [FRM_W-1:0]    req_frm_i,
  input  logic [XLEN-1:0]     req_rs1_i,
  input  logic [XLEN-1:0]     req_rs2_i,
  input  logic [XLEN-1:0]     req_rs3_i,
  input  logic [RD_W-1:0]     req_rd_i,
  input  logic                flush_i,
  output logic                fpu_start_o,
  output logic [OP_W-1:0]     fpu_op_o,
  output logic [FRM_W-1:0]    fpu_frm_o,
  output logic [XLEN-1:0]     fpu_rs1_o,
  output logic [XLEN-1:0]     fpu_rs2_o,
  output logic [XLEN-1:0]     fpu_rs3_o,
  input  logic [XLEN-1:0]     fpu_res_i,
  input  logic [FFLAGS_W-1:0] fpu_fflags_i,
  output logic                wb_valid_o,
  input  logic                wb_ready_i,
  output logic [RD_W-1:0]     wb_rd_o,
  output logic [XLEN-1:0]     wb_data_o,
  output logic [FFLAGS_W-1:0] wb_fflags_o,
  output logic                busy_o
`ifdef FPU_FFLAGS_ACCUM_EN
  ,
  input  logic                fflags_clr_i,
  output logic [FFLAGS_W-1:0] fflags_acc_o
`endif
);

  seq_state_e       state_q, state_d;
  fp_req_t          req_q;
  fp_wb_t           wb_q;
  logic             ready_q, busy_q, wb_valid_q, start_q;
  logic [CNT_W-1:0] lat_m1_c;
  logic             accept_c, capture_c, wb_fire_c;
  logic             cnt_load_c, cnt_dec_c, cnt_clr_c, cnt_zero;

  // op -> remaining EXEC cycles after the first one
  always_comb begin
    lat_m1_c = CNT_W'(LAT_DEFAULT - 1);
    case (req_op_i)
      ALU_OP_FADD, ALU_OP_FSUB: lat_m1_c = CNT_W'(LAT_ADDSUB - 1);
      default:                  lat_m1_c = CNT_W'(LAT_DEFAULT - 1);
    endcase
  end

  fpu_lat_counter #(
    .CNT_W (CNT_W)
  ) u_lat_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (cnt_clr_c),
    .load_i     (cnt_load_c),
    .load_val_i (lat_m1_c),
    .dec_i      (cnt_dec_c),
    .zero_o     (cnt_zero)
  );

  // next-state; flush overrides every state including a same-cycle request or wb handshake
  always_comb begin
    state_d    = state_q;
    accept_c   = 1'b0;
    capture_c  = 1'b0;
    wb_fire_c  = 1'b0;
    cnt_load_c = 1'b0;
    cnt_dec_c  = 1'b0;
    cnt_clr_c  = 1'b0;
    if (flush_i) begin
      state_d   = ST_IDLE;
      cnt_clr_c = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            accept_c   = 1'b1;
            cnt_load_c = 1'b1;
            state_d    = ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt_zero) begin
            capture_c = 1'b1;
            state_d   = ST_DONE;
          end else begin
            cnt_dec_c = 1'b1;
          end
        end
        ST_DONE: begin
          if (wb_ready_i) begin
            wb_fire_c = 1'b1;
            state_d   = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_q    <= (state_d == ST_IDLE);
      busy_q     <= (state_d != ST_IDLE);
      wb_valid_q <= (state_d == ST_DONE);
      start_q    <= accept_c;
    end
  end

  // operands stay frozen from accept until the next accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= '0;
    end else if (accept_c) begin
      req_q <= '{op: req_op_i, frm: req_frm_i, rs1: req_rs1_i,
                 rs2: req_rs2_i, rs3: req_rs3_i, rd: req_rd_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q <= '0;
    end else if (capture_c) begin
      wb_q <= '{rd: req_q.rd, data: fpu_res_i, fflags: fpu_fflags_i};
    end
  end

`ifdef FPU_FFLAGS_ACCUM_EN
  logic [FFLAGS_W-1:0] fflags_acc_q;

  // clear with a same-cycle writeback leaves only the new flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fflags_acc_q <= '0;
    end else if (fflags_clr_i) begin
      fflags_acc_q <= wb_fire_c ? wb_q.fflags : '0;
    end else if (wb_fire_c) begin
      fflags_acc_q <= fflags_acc_q | wb_q.fflags;
    end
  end

  assign fflags_acc_o = fflags_acc_q;
`endif

  assign req_ready_o = ready_q;
  assign busy_o      = busy_q;
  assign fpu_start_o = start_q;
  assign fpu_op_o    = req_q.op;
  assign fpu_frm_o   = req_q.frm;
  assign fpu_rs1_o   = req_q.rs1;
  assign fpu_rs2_o   = req_q.rs2;
  assign fpu_rs3_o   = req_q.rs3;
  assign wb_valid_o  = wb_valid_q;
  assign wb_rd_o     = wb_q.rd;
  assign wb_data_o   = wb_q.data;
  assign wb_fflags_o = wb_q.fflags;

endmodule
